// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, forwarding selects, MEM sequencer states, opcode classifiers.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'd0,  op_add  = 4'd1,  op_ldb  = 4'd2,  op_stb  = 4'd3,
        op_jsr  = 4'd4,  op_and  = 4'd5,  op_ldr  = 4'd6,  op_str  = 4'd7,
        op_rti  = 4'd8,  op_not  = 4'd9,  op_ldi  = 4'd10, op_sti  = 4'd11,
        op_jmp  = 4'd12, op_shf  = 4'd13, op_lea  = 4'd14, op_trap = 4'd15
    } lc3b_opcode;

    typedef enum logic [1:0] {
        fwd_rf  = 2'b00,
        fwd_mem = 2'b01,
        fwd_wb  = 2'b10
    } lc3b_fwd_sel;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MEM_P1 = 2'd1,
        MEM_P2 = 2'd2
    } lc3b_memseq_state;

    function automatic logic is_mem_op(input lc3b_opcode op);
        return op inside {op_ldb, op_ldr, op_stb, op_str, op_trap, op_ldi, op_sti};
    endfunction

    function automatic logic is_indirect(input lc3b_opcode op);
        return op inside {op_ldi, op_sti};
    endfunction

    // Ops whose result only exists after the MEM stage (load-use candidates).
    function automatic logic is_load(input lc3b_opcode op);
        return op inside {op_ldb, op_ldi, op_ldr, op_trap};
    endfunction

endpackage

// File: rtl/fwd_match.sv
// One source register against MEM/WB destinations -> forwarding select.
// Purely combinational, MEM wins over WB, unused source selects the register file.
module fwd_match
    import lc3b_types::*;
(
    input  logic [2:0]  i_src,
    input  logic        i_src_used,
    input  logic        i_mem_valid,
    input  logic        i_mem_regwrite,
    input  logic [2:0]  i_mem_dest,
    input  logic        i_wb_regwrite,
    input  logic [2:0]  i_wb_dest,
    output lc3b_fwd_sel o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_src_used & i_mem_valid & i_mem_regwrite & (i_src == i_mem_dest);
    assign w_wb_hit  = i_src_used & i_wb_regwrite & (i_src == i_wb_dest);

    always_comb begin
        o_sel = fwd_rf;
        if (w_mem_hit)
            o_sel = fwd_mem;
        else if (w_wb_hit)
            o_sel = fwd_wb;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// LC-3b hazard unit: operand forwarding, load-use bubbles, MEM access sequencing.
// Control outputs are combinational; the pipeline freezes while a data-memory access is outstanding.
module hazard_forward_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           id_sr1,
    input  logic [2:0]           id_sr2,
    input  logic                 id_sr1_used,
    input  logic                 id_sr2_used,
    input  logic [3:0]           ex_opcode,
    input  logic [2:0]           ex_dest,
    input  logic                 ex_regwrite,
    input  logic                 mem_valid,
    input  logic [3:0]           mem_opcode,
    input  logic [2:0]           mem_dest,
    input  logic                 mem_regwrite,
    input  logic [2:0]           wb_dest,
    input  logic                 wb_regwrite,
    input  logic                 dmem_resp,
    output logic [1:0]           fwd_sel_a,
    output logic [1:0]           fwd_sel_b,
    output logic                 stall_front,
    output logic                 stall_all,
    output logic                 bubble_ex,
    output logic                 dmem_read_req,
    output logic                 dmem_write_req,
    output logic                 mem_indirect_sel,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    lc3b_memseq_state      r_state;
    lc3b_memseq_state      w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic [CNT_WIDTH-1:0]  r_bubble_count;
    lc3b_opcode            w_mem_op;
    lc3b_opcode            w_ex_op;
    lc3b_fwd_sel           w_fwd_a;
    lc3b_fwd_sel           w_fwd_b;
    logic                  w_mem_access;
    logic                  w_first_write;
    logic                  w_load_use;
    logic                  w_stall_all;

    assign w_mem_op      = lc3b_opcode'(mem_opcode);
    assign w_ex_op       = lc3b_opcode'(ex_opcode);
    assign w_mem_access  = mem_valid & is_mem_op(w_mem_op);
    // First access of LDI/STI is the pointer read, so only STB/STR write first.
    assign w_first_write = w_mem_op inside {op_stb, op_str};

    fwd_match u_fwd_a (
        .i_src          (id_sr1),
        .i_src_used     (id_sr1_used),
        .i_mem_valid    (mem_valid),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_dest     (mem_dest),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_dest      (wb_dest),
        .o_sel          (w_fwd_a)
    );

    fwd_match u_fwd_b (
        .i_src          (id_sr2),
        .i_src_used     (id_sr2_used),
        .i_mem_valid    (mem_valid),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_dest     (mem_dest),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_dest      (wb_dest),
        .o_sel          (w_fwd_b)
    );

    assign fwd_sel_a = w_fwd_a;
    assign fwd_sel_b = w_fwd_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_stall_all      = 1'b0;
        dmem_read_req    = 1'b0;
        dmem_write_req   = 1'b0;
        mem_indirect_sel = 1'b0;
        case (r_state)
            RUN, MEM_P1: begin
                if (w_mem_access) begin
                    dmem_read_req  = ~w_first_write;
                    dmem_write_req = w_first_write;
                end
                if (r_state == MEM_P1 || w_mem_access) begin
                    if (!dmem_resp) begin
                        w_state_nxt = MEM_P1;
                        w_stall_all = 1'b1;
                    end else if (is_indirect(w_mem_op)) begin
                        w_state_nxt = MEM_P2;
                        w_stall_all = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            MEM_P2: begin
                mem_indirect_sel = 1'b1;
                dmem_read_req    = mem_valid & (w_mem_op == op_ldi);
                dmem_write_req   = mem_valid & (w_mem_op == op_sti);
                if (!dmem_resp)
                    w_stall_all = 1'b1;
                else
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_load_use = ex_regwrite & is_load(w_ex_op) &
                        ((id_sr1_used & (id_sr1 == ex_dest)) |
                         (id_sr2_used & (id_sr2 == ex_dest)));

    // A frozen pipeline cannot absorb a bubble; it is inserted on the release cycle instead.
    assign stall_all   = w_stall_all;
    assign stall_front = w_stall_all | w_load_use;
    assign bubble_ex   = w_load_use & ~w_stall_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
        end else begin
            if (w_stall_all && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            if (bubble_ex && r_bubble_count != '1)
                r_bubble_count <= r_bubble_count + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl with hand-computed expectations.
module tb_hazard_forward_ctrl;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  id_sr1, id_sr2, ex_dest, mem_dest, wb_dest;
    logic        id_sr1_used, id_sr2_used, ex_regwrite, mem_valid, mem_regwrite, wb_regwrite, dmem_resp;
    logic [3:0]  ex_opcode, mem_opcode;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_front, stall_all, bubble_ex, dmem_read_req, dmem_write_req, mem_indirect_sel;
    logic [15:0] stall_cycles, bubble_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_forward_ctrl #(.CNT_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_sr1           (id_sr1),
        .id_sr2           (id_sr2),
        .id_sr1_used      (id_sr1_used),
        .id_sr2_used      (id_sr2_used),
        .ex_opcode        (ex_opcode),
        .ex_dest          (ex_dest),
        .ex_regwrite      (ex_regwrite),
        .mem_valid        (mem_valid),
        .mem_opcode       (mem_opcode),
        .mem_dest         (mem_dest),
        .mem_regwrite     (mem_regwrite),
        .wb_dest          (wb_dest),
        .wb_regwrite      (wb_regwrite),
        .dmem_resp        (dmem_resp),
        .fwd_sel_a        (fwd_sel_a),
        .fwd_sel_b        (fwd_sel_b),
        .stall_front      (stall_front),
        .stall_all        (stall_all),
        .bubble_ex        (bubble_ex),
        .dmem_read_req    (dmem_read_req),
        .dmem_write_req   (dmem_write_req),
        .mem_indirect_sel (mem_indirect_sel),
        .stall_cycles     (stall_cycles),
        .bubble_count     (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
        ex_opcode = OP_ADD; ex_dest = 3'd0; ex_regwrite = 1'b0;
        mem_valid = 1'b0; mem_opcode = OP_ADD; mem_dest = 3'd0; mem_regwrite = 1'b0;
        wb_dest = 3'd0; wb_regwrite = 1'b0; dmem_resp = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] sti_resp, sti_stall, sti_ind, sti_rd, sti_wr;

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        chk("rst_bubble_count", 32'(bubble_count), 0);
        chk("rst_indirect", 32'(mem_indirect_sel), 0);
        chk("rst_stall_all", 32'(stall_all), 0);
        chk("rst_reqs", 32'({dmem_read_req, dmem_write_req}), 0);
        #11 reset = 1'b0;
        cyc();

        // 1: forwarding priority and fallback
        mem_valid = 1'b1; mem_opcode = OP_ADD; mem_dest = 3'd1; mem_regwrite = 1'b1;
        wb_dest = 3'd1; wb_regwrite = 1'b1;
        id_sr1 = 3'd1; id_sr1_used = 1'b1; id_sr2 = 3'd2; id_sr2_used = 1'b1;
        #2;
        chk("fwd_a_mem", 32'(fwd_sel_a), 1);
        chk("fwd_b_none", 32'(fwd_sel_b), 0);
        mem_regwrite = 1'b0; #1;
        chk("fwd_a_wb", 32'(fwd_sel_a), 2);
        id_sr1_used = 1'b0; #1;
        chk("fwd_a_unused", 32'(fwd_sel_a), 0);
        id_sr1_used = 1'b1; mem_regwrite = 1'b1; mem_dest = 3'd0; id_sr2 = 3'd0; #1;
        chk("fwd_b_r0_mem", 32'(fwd_sel_b), 1);
        chk("fwd_a_wb_r1", 32'(fwd_sel_a), 2);
        cyc();

        // 2: load-use bubble, then forward from MEM
        idle();
        ex_opcode = OP_LDR; ex_dest = 3'd3; ex_regwrite = 1'b1;
        id_sr1 = 3'd5; id_sr1_used = 1'b1; id_sr2 = 3'd3; id_sr2_used = 1'b1;
        #2;
        chk("lu_stall_front", 32'(stall_front), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        chk("lu_stall_all", 32'(stall_all), 0);
        cyc();
        ex_regwrite = 1'b0; ex_opcode = OP_ADD;
        mem_valid = 1'b1; mem_opcode = OP_LDR; mem_dest = 3'd3; mem_regwrite = 1'b1; dmem_resp = 1'b1;
        #2;
        chk("lu_bubble_count", 32'(bubble_count), 1);
        chk("lu_fwd_b_mem", 32'(fwd_sel_b), 1);
        chk("lu_no_bubble", 32'(bubble_ex), 0);
        chk("lu_front_free", 32'(stall_front), 0);
        chk("lu_direct_nostall", 32'(stall_all), 0);
        cyc();

        // 3: direct load with three wait cycles
        idle();
        mem_valid = 1'b1; mem_opcode = OP_LDR; mem_dest = 3'd4; mem_regwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("ldr_stall_%0d", i), 32'(stall_all), 1);
            chk($sformatf("ldr_rd_%0d", i), 32'(dmem_read_req), 1);
            cyc();
        end
        dmem_resp = 1'b1; #2;
        chk("ldr_release", 32'(stall_all), 0);
        chk("ldr_rd_last", 32'(dmem_read_req), 1);
        cyc();
        idle(); #2;
        chk("ldr_stall_cycles", 32'(stall_cycles), 3);
        chk("ldr_idle_rd", 32'(dmem_read_req), 0);
        cyc();

        // 4: STI, pointer read then data write
        sti_resp  = 7'b1000100;  // bit i = cycle i
        sti_stall = 7'b0111111;
        sti_ind   = 7'b1111000;
        sti_rd    = 7'b0000111;
        sti_wr    = 7'b1111000;
        mem_valid = 1'b1; mem_opcode = OP_STI;
        for (int i = 0; i < 7; i++) begin
            dmem_resp = sti_resp[i];
            #2;
            chk($sformatf("sti_stall_%0d", i), 32'(stall_all), 32'(sti_stall[i]));
            chk($sformatf("sti_ind_%0d", i), 32'(mem_indirect_sel), 32'(sti_ind[i]));
            chk($sformatf("sti_rd_%0d", i), 32'(dmem_read_req), 32'(sti_rd[i]));
            chk($sformatf("sti_wr_%0d", i), 32'(dmem_write_req), 32'(sti_wr[i]));
            cyc();
        end
        idle(); #2;
        chk("sti_stall_cycles", 32'(stall_cycles), 9);
        chk("sti_ind_after", 32'(mem_indirect_sel), 0);
        cyc();

        // 6: load-use coincident with a MEM stall
        mem_valid = 1'b1; mem_opcode = OP_LDR; mem_dest = 3'd6; mem_regwrite = 1'b1;
        ex_opcode = OP_LDR; ex_dest = 3'd3; ex_regwrite = 1'b1;
        id_sr1 = 3'd3; id_sr1_used = 1'b1;
        #2;
        chk("co_stall_all", 32'(stall_all), 1);
        chk("co_stall_front", 32'(stall_front), 1);
        chk("co_no_bubble", 32'(bubble_ex), 0);
        cyc();
        dmem_resp = 1'b1; #2;
        chk("co_release", 32'(stall_all), 0);
        chk("co_bubble", 32'(bubble_ex), 1);
        chk("co_front", 32'(stall_front), 1);
        cyc();
        idle(); #2;
        chk("co_bubble_count", 32'(bubble_count), 2);
        chk("co_stall_cycles", 32'(stall_cycles), 10);
        cyc();

        // 5: async reset while in MEM_P2
        mem_valid = 1'b1; mem_opcode = OP_LDI; dmem_resp = 1'b1;
        cyc();
        dmem_resp = 1'b0; #2;
        chk("p2_indirect", 32'(mem_indirect_sel), 1);
        chk("p2_ldi_rd", 32'(dmem_read_req), 1);
        reset = 1'b1; #1;
        chk("arst_indirect", 32'(mem_indirect_sel), 0);
        chk("arst_stall_cycles", 32'(stall_cycles), 0);
        chk("arst_bubble_count", 32'(bubble_count), 0);
        chk("arst_first_read", 32'(dmem_read_req), 1);
        idle();
        reset = 1'b0;
        cyc();
        #2;
        chk("post_rst_stall_cycles", 32'(stall_cycles), 0);
        chk("post_rst_stall_all", 32'(stall_all), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Pipeline hazard controller for the 5-stage LC-3b core. It drives the two EX-stage operand forwarding muxes, whose MEM-stage data and WB-stage data inputs come from the forwarding value selector. It inserts load-use bubbles. It sequences the MEM stage through single and indirect (LDI/STI) memory accesses against the data-memory handshake, freezing the pipeline while an access is outstanding.

Parameters:
CNT_WIDTH, 16, width of the saturating stall/bubble performance counters.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
id_sr1  in  3  source register 1 of instruction in ID/EX decode
id_sr2  in  3  source register 2
id_sr1_used  in  1  sr1 is read by the instruction
id_sr2_used  in  1  sr2 is read by the instruction
ex_opcode  in  4  lc3b_opcode of instruction in EX
ex_dest  in  3  EX destination register
ex_regwrite  in  1  EX instruction writes the register file
mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
mem_opcode  in  4  lc3b_opcode in MEM
mem_dest  in  3  MEM destination register
mem_regwrite  in  1  MEM writes the register file
wb_dest  in  3  WB destination register
wb_regwrite  in  1  WB writes the register file
dmem_resp  in  1  data memory completed the current access this cycle
fwd_sel_a  out  2  operand A mux: 00 regfile, 01 MEM forward, 10 WB forward
fwd_sel_b  out  2  operand B mux, same encoding
stall_front  out  1  hold PC, IF/ID and ID/EX registers
stall_all  out  1  hold every pipeline register, including EX/MEM and MEM/WB
bubble_ex  out  1  load a NOP packet into ID/EX next edge
dmem_read_req  out  1  request read to data memory
dmem_write_req  out  1  request write to data memory
mem_indirect_sel  out  1  MEM address mux selects latched mem_rdata (second LDI/STI access)
stall_cycles  out  CNT_WIDTH  count of cycles with stall_all=1, saturating
bubble_count  out  CNT_WIDTH  count of inserted bubbles, saturating

Behaviour:
- Reset (async, active-high) values: state=RUN, counters=0, mem_indirect_sel=0. Combinational outputs follow from RUN with the current inputs. Reset mid-access abandons the access and returns to RUN. No response is replayed.
- Memory ops: ldb, ldr, stb, str, trap are direct (one access). ldi and sti are indirect: the first access is always a read, and the second access uses the opcode's direction.
- FSM states: RUN, MEM_P1 (first access outstanding), MEM_P2 (second access outstanding).
- RUN, mem_valid & memory op:
  - dmem_resp=0 -> MEM_P1, stall_all=1.
  - dmem_resp=1 & indirect -> MEM_P2, stall_all=1.
  - dmem_resp=1 & direct -> stay in RUN, no stall.
- MEM_P1: hold while dmem_resp=0, with stall_all=1.
  - dmem_resp=1 & indirect -> MEM_P2, stall_all=1.
  - dmem_resp=1 & direct -> RUN, stall_all=0 in this cycle (release).
- MEM_P2: mem_indirect_sel=1. Hold with stall_all=1 until dmem_resp=1, then go to RUN with stall_all=0 in that cycle.
- Memory requests:
  - dmem_read_req=1 in a first access when the op is a load, trap, ldi or sti; it also covers the second access of ldi.
  - dmem_write_req=1 for stb/str, and for the second access of sti.
  - Both requests are 0 when mem_valid=0.
- Load-use: asserted when ex_regwrite & ex_opcode in {ldb, ldi, ldr, trap} & ((id_sr1_used & id_sr1==ex_dest) | (id_sr2_used & id_sr2==ex_dest)).
  - In that case stall_front=1 and bubble_ex=1, only when stall_all=0.
  - stall_all dominates: when it is 1, bubble_ex=0 and stall_front=1.
- Forwarding (combinational, per operand):
  - MEM match (mem_valid & mem_regwrite & dest equal) gives 01.
  - Otherwise a WB match (wb_regwrite & dest equal) gives 10.
  - Otherwise 00.
  - MEM has priority over WB. An unused source gives 00. R0 is an ordinary register (no zero-register exception).
- Counters increment on clock edges where the condition holds, saturate at all-ones, and are never cleared except by reset.

Decomposition:
- Add to lc3b_types:
  - enum lc3b_fwd_sel {fwd_rf=2'b00, fwd_mem=2'b01, fwd_wb=2'b10}.
  - enum lc3b_memseq_state {RUN, MEM_P1, MEM_P2}.
  - Functions is_mem_op(), is_indirect(), is_load() over lc3b_opcode.
- One sub-module: fwd_match. It is purely combinational: one source register against the MEM and WB destinations, producing lc3b_fwd_sel. It is instantiated twice.

Test Plan:
1. ADD R1 in MEM, ADD reading R1 as sr1 in ID, WB also writing R1 -> fwd_sel_a=01, fwd_sel_b=00. With MEM regwrite=0 -> fwd_sel_a=10.
2. LDR R3 in EX, ADD reading R3 as sr2 -> one cycle with stall_front=1 and bubble_ex=1; bubble_count=1; next cycle fwd_sel_b=01.
3. LDR in MEM, dmem_resp low for 3 cycles then high -> stall_all=1 for exactly 3 cycles, stall_cycles=3, state returns to RUN, dmem_read_req high throughout.
4. STI in MEM, with first dmem_resp after 2 cycles and second after 4 -> mem_indirect_sel=1 only in MEM_P2. Read request during the first access, write request during the second. stall_all=1 for 6 cycles.
5. Reset asserted while in MEM_P2 -> state=RUN immediately (async), mem_indirect_sel=0, counters=0.
6. Load-use hazard coincident with a MEM stall -> bubble_ex=0, stall_front=1. The bubble is inserted in the release cycle.
